// File: rtl/stage4_normalize_pkg.sv
// Shared FP16 constants and the stage4 -> stage5 bundle type for the SD4 MAC pipeline.
package stage4_normalize_pkg;

    localparam int BIAS    = 15;
    localparam int EXP_MAX = 31;
    localparam int MANT_W  = 11;
    localparam int EXP_MIN = -32;

    typedef struct packed {
        logic              sign;
        logic [6:0]        exp_final;
        logic [MANT_W-1:0] norm_sum;
    } stage4_out_t;

endpackage

// File: rtl/stage4_normalize_leading_one_detector.sv
// Priority encoder returning the index of the most significant set bit of mag.
module leading_one_detector #(
    parameter int SUM_W = 24,
    parameter int P_W   = $clog2(SUM_W)
) (
    input  logic [SUM_W-1:0] mag,
    output logic [P_W-1:0]   pos,
    output logic             zero
);

    // Ascending scan: the highest set bit is the last assignment and wins.
    always_comb begin
        pos = '0;
        for (int i = 0; i < SUM_W; i++) begin
            if (mag[i]) begin
                pos = P_W'(i);
            end
        end
        zero = (mag == '0);
    end

endmodule

// File: rtl/stage4_normalize.sv
// Normalization stage: leading-one detect, mantissa shift, exponent adjust/clamp.
// Define STAGE4_ROUND_NEAREST_EVEN_EN for round-to-nearest-even instead of truncation.
module stage4_normalize #(
    parameter int SUM_W   = 24,
    parameter int FRAC_W  = 20,
    parameter int EXP_MIN = stage4_normalize_pkg::EXP_MIN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sign_in,
    input  logic [7:0]       exp_in,
    input  logic [SUM_W-1:0] mag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             sign,
    output logic [6:0]       exp_final,
    output logic [10:0]      norm_sum
);

    import stage4_normalize_pkg::*;

    localparam int P_W = $clog2(SUM_W);
    localparam int HID = MANT_W - 1;

    logic [P_W-1:0]   lod_pos;
    logic             lod_zero;

    logic             s1_valid_q, s1_valid_d;
    logic             s1_sign_q,  s1_sign_d;
    logic [7:0]       s1_exp_q,   s1_exp_d;
    logic [SUM_W-1:0] s1_mag_q,   s1_mag_d;
    logic [P_W-1:0]   s1_p_q,     s1_p_d;
    logic             s1_zero_q,  s1_zero_d;

    logic             out_valid_q, out_valid_d;
    stage4_out_t      out_q, out_d;

    logic             s2_adv;
    logic [P_W-1:0]   sh_r, sh_l;
    logic [MANT_W-1:0] m, m_fin;
    logic [MANT_W:0]  m_rnd;
    logic signed [9:0] e, e_adj;
    logic             round_inc;
    stage4_out_t      res;
`ifdef STAGE4_ROUND_NEAREST_EVEN_EN
    logic             guard, sticky;
`endif

    leading_one_detector #(.SUM_W(SUM_W), .P_W(P_W)) u_lod (
        .mag  (mag_in),
        .pos  (lod_pos),
        .zero (lod_zero)
    );

    // Whole-pipeline advance: S2 frees when empty or drained, S1 moves when S2 frees.
    always_comb begin
        s2_adv   = !out_valid_q || out_ready;
        in_ready = !s1_valid_q || s2_adv;

        s1_valid_d = s1_valid_q;
        s1_sign_d  = s1_sign_q;
        s1_exp_d   = s1_exp_q;
        s1_mag_d   = s1_mag_q;
        s1_p_d     = s1_p_q;
        s1_zero_d  = s1_zero_q;
        if (in_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_sign_d = sign_in;
                s1_exp_d  = exp_in;
                s1_mag_d  = mag_in;
                s1_p_d    = lod_pos;
                s1_zero_d = lod_zero;
            end
        end

        out_valid_d = out_valid_q;
        out_d       = out_q;
        if (s2_adv) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_d = res;
            end
        end
    end

    always_comb begin
        sh_r = s1_p_q - P_W'(HID);
        sh_l = P_W'(HID) - s1_p_q;
        if (s1_p_q >= P_W'(HID)) begin
            m = MANT_W'(s1_mag_q >> sh_r);
        end else begin
            m = MANT_W'(s1_mag_q << sh_l);
        end

`ifdef STAGE4_ROUND_NEAREST_EVEN_EN
        guard  = 1'b0;
        sticky = 1'b0;
        if (s1_p_q > P_W'(HID)) begin
            guard  = s1_mag_q[sh_r - P_W'(1)];
            sticky = |(s1_mag_q & ((SUM_W'(1) << (sh_r - P_W'(1))) - SUM_W'(1)));
        end
        round_inc = guard && (sticky || m[0]);
`else
        round_inc = 1'b0;
`endif

        m_rnd = {1'b0, m} + (MANT_W+1)'(round_inc);
        e     = 10'(signed'(s1_exp_q)) + 10'(s1_p_q) - 10'(FRAC_W);
        // Rounding carry out of 0x7FF renormalizes to 1.0 at the next exponent.
        if (m_rnd[MANT_W]) begin
            m_fin = MANT_W'(1 << HID);
            e_adj = e + 10'sd1;
        end else begin
            m_fin = m_rnd[MANT_W-1:0];
            e_adj = e;
        end

        res.sign = s1_sign_q;
        if (s1_zero_q) begin
            res.exp_final = 7'd0;
            res.norm_sum  = '0;
        end else if (e_adj >= 10'(EXP_MAX)) begin
            res.exp_final = 7'(EXP_MAX);
            res.norm_sum  = '0;
        end else if (e_adj < 10'(EXP_MIN)) begin
            res.exp_final = 7'(EXP_MIN);
            res.norm_sum  = m_fin;
        end else begin
            res.exp_final = e_adj[6:0];
            res.norm_sum  = m_fin;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_exp_q    <= '0;
            s1_mag_q    <= '0;
            s1_p_q      <= '0;
            s1_zero_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sign_q   <= s1_sign_d;
            s1_exp_q    <= s1_exp_d;
            s1_mag_q    <= s1_mag_d;
            s1_p_q      <= s1_p_d;
            s1_zero_q   <= s1_zero_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
        end
    end

    assign out_valid = out_valid_q;
    assign sign      = out_q.sign;
    assign exp_final = out_q.exp_final;
    assign norm_sum  = out_q.norm_sum;

endmodule
